skid_reg: RTL
=============

# skid_reg

Registered two-entry skid buffer that sits directly downstream of the operand/stream mux and captures its `pStreamBits`-wide output into the next pipeline stage. It converts the mux output into a valid/ready stream, fully registering both the data path and the backpressure path (`oReady`). Throughput is one word per cycle and there is no combinational path from `iReady` to `oReady`. A synchronous flush drops in-flight words on pipeline redirect.

## Interface
- `pStreamBits`, 32, data width in bits (≥1)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `iFlush`  in  1  synchronous flush; empties the buffer at the next edge
- `iValid`  in  1  upstream word present on `iData`
- `iData`  in  pStreamBits  upstream word, from the mux output
- `oReady`  out  1  buffer can accept a word this cycle (registered)
- `oValid`  out  1  `oData` holds a valid word
- `oData`  out  pStreamBits  head word (registered)
- `iReady`  in  1  downstream accepts the head word this cycle
- `oLevel`  out  2  occupancy, 0..2

## Operation
- Transfer definitions: `in_fire = iValid & oReady`; `out_fire = oValid & iReady`.
- Storage consists of a main register (drives `oData`) and a skid register.
- States (encoded as occupancy):
  - EMPTY (0)
    - in_fire: main←iData → BUSY
    - otherwise stay
  - BUSY (1)
    - in_fire & !out_fire: skid←iData → FULL
    - !in_fire & out_fire: → EMPTY
    - in_fire & out_fire: main←iData, stay BUSY
    - neither: hold
  - FULL (2)
    - out_fire: main←skid → BUSY
    - otherwise hold
    - in_fire is impossible because `oReady`=0
- Derived outputs:
  - `oValid` = (state≠EMPTY)
  - `oLevel` = state
  - `oReady` is registered; next value = (next_state≠FULL)
- `iFlush` has priority over everything:
  - Next state EMPTY, `oReady`←1.
  - A word presented with `iFlush` high is dropped, even if in_fire.
  - Data registers may keep stale contents.
- Ordering is strict FIFO. No word is duplicated or lost except by flush or reset.
- `oData` and skid contents are don't-care while not valid, but must be 0 after reset.

## Timing
- Reset, asynchronous and immediate on `rst` rising:
  - state EMPTY
  - `oValid`=0, `oLevel`=0, `oData`=0, skid=0
  - `oReady`=1
- Reset mid-operation discards all buffered words. The first edge after `rst` falls behaves as EMPTY.
- Latency: a word accepted at edge N is on `oData` with `oValid`=1 after edge N (1 cycle).
- Throughput: with `iValid`=`iReady`=1 continuously, one word per cycle and the buffer stays at level 1.
- Backpressure:
  - If `iReady` drops while streaming, one more word is absorbed into skid.
  - `oReady` falls after that edge.
  - `oReady` returns to 1 the edge after the first subsequent out_fire.
- `iData` is sampled only on in_fire; `iValid` may toggle freely.
- Downstream may lower `iReady` at any time. `oData` stays stable while `oValid`=1 and `iReady`=0.

## Test plan
- **Reset values:** assert `rst` asynchronously mid-cycle with level 2 buffered → `oValid`=0, `oLevel`=0, `oData`=0, `oReady`=1 immediately, before the next clock edge.
- **Single word:** `iData`=0x0000_00A5, `iValid`=1 for 1 cycle, `iReady`=0 → after that edge `oValid`=1, `oData`=0xA5, `oLevel`=1. Then raise `iReady` for 1 cycle → `oValid`=0.
- **Streaming:** send 0x1,0x2,…,0x10 back-to-back with `iReady`=1 → 16 outputs in order, one per cycle, `oLevel` constant 1, `oReady` never 0.
- **Backpressure/skid:** stream 0x11,0x12,0x13 and drop `iReady` before 0x12 is consumed → level 2, `oReady`=0, 0x13 held upstream. Raise `iReady` → outputs 0x11,0x12,0x13 in order, `oReady` back to 1 one edge after first out_fire.
- **Flush:** at level 2 (0xAA,0xBB), assert `iFlush` with `iValid`=1, `iData`=0xCC → next edge `oValid`=0, `oLevel`=0, `oReady`=1. 0xCC never appears.
- **Random:** random `iValid`/`iReady` over 10,000 cycles against a queue model → exact order, no loss or duplication, `oLevel` ≤ 2, `oData` stable while stalled.

Source files
------------

// File: rtl/skid_reg.sv
// Two-entry skid buffer with registered data and a registered oReady; 1-cycle latency, one word/cycle.
// Backpressure: oReady drops only after the skid register has absorbed a word, so no iReady->oReady path exists.
module skid_reg #(
  parameter int pStreamBits = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iFlush,
  input  logic                   iValid,
  input  logic [pStreamBits-1:0] iData,
  output logic                   oReady,
  output logic                   oValid,
  output logic [pStreamBits-1:0] oData,
  input  logic                   iReady,
  output logic [1:0]             oLevel
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [pStreamBits-1:0] main_q, main_d;
  logic [pStreamBits-1:0] skid_q, skid_d;
  logic                   ready_q;
  logic                   in_fire, out_fire;

  assign in_fire  = iValid & ready_q;
  assign out_fire = (state_q != EMPTY) & iReady;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (iFlush) begin
      // Data registers are left stale; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = iData;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && !out_fire) begin
            skid_d  = iData;
            state_d = FULL;
          end else if (!in_fire && out_fire) begin
            state_d = EMPTY;
          end else if (in_fire && out_fire) begin
            main_d  = iData;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  assign oReady = ready_q;
  assign oValid = (state_q != EMPTY);
  assign oData  = main_q;
  assign oLevel = state_q;

endmodule
